// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divide sequencer: FSM encoding and timeout default.
`timescale 1ns/1ps
package div_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam int DIV_TIMEOUT_DEFAULT = 16;
  localparam int CNT_W               = 5;

endpackage

// File: rtl/div_sequencer_if.sv
// Start/Ready handshake and operand/result bus between sequencer and the shared divider.
`timescale 1ns/1ps
interface div_sequencer_if;

  logic        div_start;
  logic        div_signed;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [63:0] div_result;
  logic        div_ready;

  modport master (
    output div_start, div_signed, div_a, div_b,
    input  div_result, div_ready
  );

  modport slave (
    input  div_start, div_signed, div_a, div_b,
    output div_result, div_ready
  );

endinterface

// File: rtl/div_sequencer.sv
// Sequences DIV/DIVU through the shared divider: stalls EX, issues a level-held Start,
// returns {HI, LO} as a one-cycle strobe, and drains flushed divides without writing back.
`timescale 1ns/1ps
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  input  logic                  i_req_signed,
  input  logic [31:0]           i_req_a,
  input  logic [31:0]           i_req_b,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic                  o_busy,
  output logic                  o_hilo_we,
  output logic [31:0]           o_hi_wdata,
  output logic [31:0]           o_lo_wdata,
  output logic                  o_timeout_err,
  div_sequencer_if.master       div_bus
);

  state_e             r_state;
  state_e             w_state_next;
  logic               r_cancel;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_timeout_err;
  logic               r_div_start;
  logic               r_div_signed;
  logic [31:0]        r_div_a;
  logic [31:0]        r_div_b;

  logic               w_accept;
  logic               w_complete;
  logic               w_stall;
  logic               w_hilo_we;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_complete   = 1'b0;
    w_stall      = 1'b0;
    w_hilo_we    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req_valid && !i_flush && (i_req_b != 32'd0)) begin
          w_accept     = 1'b1;
          w_stall      = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        // A cancelled divide no longer holds its own instruction, only whatever sits behind it.
        w_stall = (!r_cancel && !div_bus.div_ready) || (r_cancel && i_req_valid);
        if (div_bus.div_ready) begin
          w_complete   = 1'b1;
          w_hilo_we    = !r_cancel && !i_flush;
          w_state_next = RELEASE;
        end
      end
      RELEASE: begin
        w_stall = i_req_valid;
        if (!div_bus.div_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments and clears on the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_start   <= 1'b0;
      r_div_signed  <= 1'b0;
      r_div_a       <= 32'd0;
      r_div_b       <= 32'd0;
      r_cancel      <= 1'b0;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_div_start  <= 1'b1;
        r_div_signed <= i_req_signed;
        r_div_a      <= i_req_a;
        r_div_b      <= i_req_b;
        r_cancel     <= 1'b0;
        r_cnt        <= '0;
      end else if (w_complete) begin
        r_div_start <= 1'b0;
      end
      if (r_state == RUN) begin
        if (i_flush)    r_cancel <= 1'b1;
        if (r_cnt != '1) r_cnt   <= r_cnt + 1'b1;
        // The FSM keeps waiting after a timeout; the flag is diagnostic only.
        if ((int'(r_cnt) + 1) >= DIV_TIMEOUT) r_timeout_err <= 1'b1;
      end
    end
  end

  assign o_stall       = w_stall;
  assign o_busy        = (r_state != IDLE);
  assign o_hilo_we     = w_hilo_we;
  assign o_hi_wdata    = w_complete ? div_bus.div_result[63:32] : 32'd0;
  assign o_lo_wdata    = w_complete ? div_bus.div_result[31:0]  : 32'd0;
  assign o_timeout_err = r_timeout_err;

  assign div_bus.div_start  = r_div_start;
  assign div_bus.div_signed = r_div_signed;
  assign div_bus.div_a      = r_div_a;
  assign div_bus.div_b      = r_div_b;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a behavioural divider model and a {HI,LO} scoreboard.
`timescale 1ns/1ps
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_signed, flush;
  logic [31:0] req_a, req_b;
  logic        stall, busy, hilo_we, timeout_err;
  logic [31:0] hi_wdata, lo_wdata;
  logic        stub;

  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  logic [63:0] exp_q[$];
  int unsigned dcnt;

  always #5 clk = ~clk;

  div_sequencer_if bus ();

  div_sequencer #(.DIV_TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_valid   (req_valid),
    .i_req_signed  (req_signed),
    .i_req_a       (req_a),
    .i_req_b       (req_b),
    .i_flush       (flush),
    .o_stall       (stall),
    .o_busy        (busy),
    .o_hilo_we     (hilo_we),
    .o_hi_wdata    (hi_wdata),
    .o_lo_wdata    (lo_wdata),
    .o_timeout_err (timeout_err),
    .div_bus       (bus)
  );

  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Divider model: counts 8 rising edges with Start held, raises Ready, drops it on a falling edge once Start is low.
  always @(posedge clk or negedge clk or posedge rst) begin
    if (rst) begin
      dcnt           <= 0;
      bus.div_ready  <= 1'b0;
      bus.div_result <= '0;
    end else if (clk) begin
      if (bus.div_start && !bus.div_ready && !stub) begin
        dcnt <= dcnt + 1;
        if (dcnt == 7) begin
          bus.div_ready  <= 1'b1;
          bus.div_result <= ref_div(bus.div_signed, bus.div_a, bus.div_b);
        end
      end
    end else if (!bus.div_start && bus.div_ready) begin
      bus.div_ready <= 1'b0;
      dcnt          <= 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock; samples 3 ns after the rising edge and scores any HI/LO write seen.
  task automatic cyc();
    logic [63:0] e;
    @(posedge clk);
    #3;
    if (hilo_we) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        chk("spurious_hilo_we", 64'(hilo_we), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("hilo_data", {hi_wdata, lo_wdata}, e);
      end
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] a, input logic [31:0] b);
    req_valid  = v;
    req_signed = s;
    req_a      = a;
    req_b      = b;
  endtask

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo);
    drive(1'b1, s, a, b);
    #1;
    chk("accept_stall", 64'({stall, busy}), 64'b10);
    exp_q.push_back({ehi, elo});
  endtask

  task automatic wait_done();
    int n;
    n = 1;
    cyc();
    chk("start_t1", 64'(bus.div_start), 64'd1);
    while (stall && n < 40) begin
      n++;
      cyc();
    end
    chk("stall_cycles", 64'(n), 64'd9);
    chk("complete_we", 64'(hilo_we), 64'd1);
  endtask

  task automatic finish_idle();
    req_valid = 1'b0;
    cyc();
    chk("release", 64'({busy, bus.div_start, stall}), 64'b100);
    cyc();
    chk("back_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    stub  = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #3;
    chk("rst_ctrl", 64'({stall, busy, hilo_we, timeout_err, bus.div_start, bus.div_signed}), 64'd0);
    chk("rst_wdata", {hi_wdata, lo_wdata}, 64'd0);
    chk("rst_ops", {bus.div_a, bus.div_b}, 64'd0);
    rst = 1'b0;
    cyc();

    // DIVU 100/7
    issue(1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
    wait_done();
    finish_idle();

    // DIV -7/2
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_done();
    finish_idle();

    // Divide by zero: never issued
    drive(1'b1, 1'b0, 32'd5, 32'd0);
    #1;
    chk("div0_stall", 64'(stall), 64'd0);
    repeat (4) begin
      cyc();
      chk("div0_idle", 64'({stall, busy, bus.div_start}), 64'd0);
    end
    req_valid = 1'b0;
    cyc();

    // Flush at T+4, then DIVU 9/3 queued behind the cancelled divide
    drive(1'b1, 1'b0, 32'd50, 32'd5);
    #1;
    chk("flush_accept", 64'(stall), 64'd1);
    repeat (4) cyc();
    flush     = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("flush_cycle_stall", 64'(stall), 64'd1);
    cyc();
    flush = 1'b0;
    drive(1'b1, 1'b0, 32'd9, 32'd3);
    #1;
    chk("cancel_stall_new", 64'(stall), 64'd1);
    repeat (4) begin
      cyc();
      chk("cancel_start_held", 64'(bus.div_start), 64'd1);
    end
    chk("cancel_complete", 64'({bus.div_ready, hilo_we, stall, bus.div_start}), 64'b1011);
    cyc();
    chk("cancel_release", 64'({busy, stall, bus.div_start}), 64'b110);
    cyc();
    chk("cancel_idle", 64'(busy), 64'd0);
    issue(1'b0, 32'd9, 32'd3, 32'd0, 32'd3);
    wait_done();
    finish_idle();

    // Back-to-back: second request already waiting when the first completes
    issue(1'b0, 32'd10, 32'd3, 32'd1, 32'd3);
    wait_done();
    drive(1'b1, 1'b0, 32'h8000_0000, 32'd1);
    cyc();
    chk("b2b_release", 64'({busy, stall, bus.div_start, bus.div_ready}), 64'b1101);
    cyc();
    chk("b2b_ready_low", 64'({busy, bus.div_ready, bus.div_start}), 64'd0);
    issue(1'b0, 32'h8000_0000, 32'd1, 32'd0, 32'h8000_0000);
    wait_done();
    finish_idle();

    // Divider that never answers
    stub = 1'b1;
    drive(1'b1, 1'b0, 32'd1, 32'd1);
    repeat (16) cyc();
    chk("timeout_not_yet", 64'({timeout_err, stall}), 64'b01);
    cyc();
    chk("timeout_set", 64'(timeout_err), 64'd1);
    repeat (8) cyc();
    chk("timeout_sticky", 64'({timeout_err, busy, bus.div_start}), 64'b111);
    req_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("timeout_rst", 64'({timeout_err, busy, bus.div_start, stall}), 64'd0);
    chk("timeout_rst_ops", {bus.div_a, bus.div_b}, 64'd0);
    cyc();
    rst  = 1'b0;
    stub = 1'b0;
    cyc();

    issue(1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 32'h0FFF_FFFF);
    wait_done();
    finish_idle();

    chk("hilo_we_count", 64'(we_cnt), 64'd6);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Sequences the shared Goldschmidt divider for the EX stage of the CPU pipeline. Accepts DIV/DIVU requests, drives the divider's level-held Start/Ready handshake, stalls the pipeline for the divide, and returns {HI, LO} as a one-cycle write pulse. Handles pipeline flushes by letting an in-flight divide run to completion and discarding its result, because the divider has no abort.

## Interface
- DIV_TIMEOUT, 16: RUN-state cycle count at which `timeout_err` is set.
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  EX stage holds a divide instruction
- req_signed  in  1  1 = DIV, 0 = DIVU
- req_a  in  32  dividend
- req_b  in  32  divisor
- flush  in  1  pipeline flush/exception; kills the EX instruction
- stall  out  1  hold the EX stage
- busy  out  1  state != IDLE
- hilo_we  out  1  HI/LO write strobe
- hi_wdata  out  32  remainder = div_result[63:32]
- lo_wdata  out  32  quotient = div_result[31:0]
- timeout_err  out  1  sticky diagnostic
- div_start  out  1  divider Start, registered
- div_signed, div_a[31:0], div_b[31:0]  out  registered operands, stable while div_start=1
- div_result  in  64  {remainder, quotient}
- div_ready  in  1  divider Ready

## Operation
- States: IDLE, RUN, RELEASE. Additional state: cancel flag, timeout counter (5 bits, saturating).
- IDLE, with `req_valid && !flush && req_b!=0`: latch the operands into the div_* registers, set div_start, clear cancel and the counter, move to RUN. `stall=1` in the accept cycle.
- IDLE, with `req_valid && !flush && req_b==0`: divide by zero. No issue, `stall=0`, `hilo_we=0`, so HI/LO are unchanged.
- IDLE with flush: nothing is accepted.
- RUN: div_start stays at 1. Never deassert it before div_ready, because the divider would resume the stale operation on the next Start.
  - `stall = !cancel && !div_ready`, OR'd with `req_valid` when cancel is set (a new instruction behind a flushed divide waits).
  - `flush` in RUN sets cancel.
- RUN with div_ready (completion cycle):
  - `hilo_we = !cancel && !flush` (flush has precedence).
  - hi/lo_wdata driven combinationally from div_result.
  - div_start cleared at the next edge, move to RELEASE.
- RELEASE: `div_start=0`, `stall=req_valid`. Move to IDLE when `div_ready==0`. No request is accepted in RELEASE.
- Timeout: the counter increments each RUN cycle. Reaching DIV_TIMEOUT sets timeout_err, which holds until rst. The FSM keeps waiting.
- Reset mid-operation: return to IDLE immediately, all outputs take their reset values. The divider is reset by the same rst.

## Timing
- Reset values: stall=0, busy=0, hilo_we=0, hi/lo_wdata=0, timeout_err=0, div_start=0, div_signed=0, div_a=0, div_b=0, state=IDLE, cancel=0.
- Accept at cycle T; div_start=1 from T+1.
- The divider samples Start over 8 edges (load, 5 iterations, remainder, result), so div_ready is high in T+9.
- stall is 1 for T..T+8 and 0 in the completion cycle T+9, where hilo_we=1 and EX advances at the end of T+9.
- T+10 is RELEASE. div_ready is low by T+11, since the divider clears Ready on the falling edge. The next divide is accepted at T+11 at the earliest.
- hilo_we is exactly one cycle per completed, uncancelled divide.

## Structure
- Shared package: the state encoding (IDLE=2'd0, RUN=2'd1, RELEASE=2'd2) and the DIV_TIMEOUT default.
- No sub-module. The divider is instantiated beside this block at EX level, not inside it.

## Test plan
- DIVU 100/7 accepted at T → stall for 9 cycles, then hilo_we at T+9 with hi=2, lo=14, then RELEASE → IDLE.
- DIV 0xFFFFFFF9 / 2 (-7/2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 5/0 → stall=0, hilo_we never asserts, div_start never asserts.
- Flush at T+4 followed by a new DIVU 9/3 request → div_start held through T+9, no hilo_we at T+9, the new request stalled and accepted after RELEASE, giving hi=0, lo=3.
- Back-to-back DIVU 10/3 and 0x80000000/1 → the second div_start rises only after div_ready has gone low. Results hi=1, lo=3, then hi=0, lo=0x80000000.
- Stubbed divider that never sets div_ready → timeout_err set after 16 RUN cycles and stays set. Asserting rst clears it and returns the FSM to IDLE.
